// File: rtl/cs_pkg.sv
// Shared definitions for the cs_seq control sequencer: state encoding and default opcodes.
package cs_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_ULA_OP    = 4'd3,
        S_ULA_WAIT  = 4'd4,
        S_STORE_RES = 4'd5,
        S_HALT      = 4'd6
    } state_t;

    localparam logic [3:0] OP_JMP_DEF  = 4'hE;
    localparam logic [3:0] OP_HALT_DEF = 4'hF;

endpackage

// File: rtl/cs_wait_timer.sv
// Cycle counter for multi-cycle ULA waits; flags the last permitted wait cycle.
module cs_wait_timer
    import cs_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] count;

    // Saturates at WAIT_MAX so a stalled enable can never wrap back into range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_TOP)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_LAST);

endmodule

// File: rtl/cs_seq.sv
// Instruction sequencer: fetches opcodes from ROM, steps the ULA through single or
// multi-cycle operations, handles jump/halt and a run/stop request.
module cs_seq
    import cs_pkg::*;
#(
    parameter int                       OPCODE_W   = 4,
    parameter logic [2**OPCODE_W-1:0]   MC_OP_MASK = 16'h0000,
    parameter logic [OPCODE_W-1:0]      OP_JMP     = OP_JMP_DEF,
    parameter logic [OPCODE_W-1:0]      OP_HALT    = OP_HALT_DEF,
    parameter int                       WAIT_MAX   = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                rom_ready,
    input  logic                ula_done,
    output logic [3:0]          state,
    output logic                rom_read,
    output logic                pc_increment,
    output logic                pc_load,
    output logic                gp_read,
    output logic                latch_ula,
    output logic                grab_ula,
    output logic                gp_write,
    output logic [OPCODE_W-1:0] ula_operation,
    output logic                halted,
    output logic                timeout_err
);

    state_t              cur;
    logic [OPCODE_W-1:0] op_q;
    logic                wait_expired;

    cs_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cur == S_ULA_OP),
        .enable  (cur == S_ULA_WAIT),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= S_IDLE;
            op_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (run) cur <= S_FETCH;
                end
                S_FETCH: begin
                    if (rom_ready) begin
                        op_q <= opcode;
                        cur  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op_q == OP_HALT)     cur <= S_HALT;
                    else if (op_q == OP_JMP) cur <= run ? S_FETCH : S_IDLE;
                    else                     cur <= S_ULA_OP;
                end
                S_ULA_OP: begin
                    cur <= MC_OP_MASK[op_q] ? S_ULA_WAIT : S_STORE_RES;
                end
                S_ULA_WAIT: begin
                    // A result arriving on the final wait cycle still counts as success.
                    if (ula_done) begin
                        cur <= S_STORE_RES;
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                        cur         <= S_HALT;
                    end
                end
                S_STORE_RES: begin
                    cur <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    cur <= S_HALT;
                end
                default: begin
                    cur <= S_IDLE;
                end
            endcase
        end
    end

    assign state         = cur;
    assign ula_operation = op_q;
    assign rom_read      = (cur == S_FETCH);
    assign pc_increment  = (cur == S_FETCH) && rom_ready;
    assign pc_load       = (cur == S_DECODE) && (op_q == OP_JMP) && (op_q != OP_HALT);
    assign gp_read       = (cur == S_ULA_OP);
    assign latch_ula     = (cur == S_ULA_OP);
    assign grab_ula      = (cur == S_STORE_RES);
    assign gp_write      = (cur == S_STORE_RES);
    assign halted        = (cur == S_HALT);

endmodule

// File: doc/cs_seq.md
Name: cs_seq

Overview:
Parametrised control sequencer for the processor core.
- Successor to the combinational signal-control unit: owns the instruction state machine instead of decoding an external state.
- Adds a ROM ready handshake, multi-cycle ULA operations with a timeout, jump and halt opcodes, and a run/stop control.
- Sits between instruction ROM, PC, register file (gp) and ULA; drives their strobes.

Parameters:
- OPCODE_W, 4, opcode width; ula_operation has the same width.
- MC_OP_MASK, 16'h0000, bit i set = opcode i is multi-cycle (waits for ula_done); width 2**OPCODE_W.
- OP_JMP, 4'hE, jump opcode (no ULA activity, loads PC).
- OP_HALT, 4'hF, halt opcode.
- WAIT_MAX, 15, maximum cycles spent in S_ULA_WAIT before timeout; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = fetch/execute instructions; 0 = stop after the current instruction.
- opcode  in  OPCODE_W  instruction opcode from ROM; valid when rom_ready=1.
- rom_ready  in  1  ROM data valid; sampled only in S_FETCH.
- ula_done  in  1  multi-cycle ULA result ready; sampled only in S_ULA_WAIT.
- state  out  4  current state encoding (cs_pkg).
- rom_read  out  1  ROM read request.
- pc_increment  out  1  one-cycle PC increment strobe.
- pc_load  out  1  one-cycle PC load strobe (jump).
- gp_read  out  1  register-file read strobe.
- latch_ula  out  1  ULA operand latch strobe.
- grab_ula  out  1  capture ULA result.
- gp_write  out  1  register-file write strobe.
- ula_operation  out  OPCODE_W  latched opcode.
- halted  out  1  core halted.
- timeout_err  out  1  sticky error: a multi-cycle op exceeded WAIT_MAX.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = S_IDLE; op_q = 0; wait counter = 0; timeout_err = 0.
  - All strobes, halted and ula_operation read 0.
  - Reset applied mid-instruction aborts it immediately.
- Strobes are Moore decodes of the registered state, except pc_increment, which is Mealy.
- ula_operation = op_q.
- S_IDLE:
  - No strobes.
  - run=1 -> S_FETCH; otherwise stay.
- S_FETCH:
  - rom_read=1, held until the handshake completes.
  - pc_increment = rom_ready: exactly one cycle per fetch.
  - When rom_ready=1: op_q <= opcode, then -> S_DECODE.
  - When rom_ready=0: stay, with no time limit.
- S_DECODE:
  - op_q==OP_HALT -> S_HALT.
  - op_q==OP_JMP: pc_load=1 this cycle, then -> S_FETCH if run, else S_IDLE.
  - Any other opcode -> S_ULA_OP.
- S_ULA_OP:
  - gp_read=1 and latch_ula=1 for exactly one cycle.
  - MC_OP_MASK[op_q]=1 -> S_ULA_WAIT with counter cleared; otherwise -> S_STORE_RES.
  - ula_done is ignored in this state.
- S_ULA_WAIT:
  - No strobes; the counter increments each cycle.
  - ula_done=1 -> S_STORE_RES. ula_done takes priority over timeout in the same cycle.
  - Timeout: counter==WAIT_MAX-1 and ula_done=0 -> timeout_err <= 1, then -> S_HALT.
  - Counter width is $clog2(WAIT_MAX+1); it never wraps.
- S_STORE_RES:
  - grab_ula=1 and gp_write=1 for one cycle.
  - -> S_FETCH if run, else S_IDLE.
- S_HALT:
  - halted=1; no strobes.
  - Terminal until rst_n is asserted; run is ignored.
- run deasserted mid-instruction:
  - The current instruction completes.
  - The block returns to S_IDLE at the next decision point: after STORE_RES or a JMP decode.
- Latency, single-cycle op with rom_ready already high: FETCH -> DECODE -> ULA_OP -> STORE_RES, 4 cycles per instruction.
- op_q changes only at the FETCH->DECODE transition, so ula_operation is stable from DECODE through STORE_RES.

Decomposition:
- Package cs_pkg:
  - State localparams: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_ULA_OP=3, S_ULA_WAIT=4, S_STORE_RES=5, S_HALT=6; 4-bit width.
  - Default OP_JMP and OP_HALT constants.
- Sub-module cs_wait_timer:
  - Parametrised by WAIT_MAX.
  - Inputs: clear, enable. Output: expired.
  - Asynchronous active-low reset.

Test Plan:
- Reset then run=1, rom_ready=1, opcode=4'h2 (single-cycle) -> state sequence 1,2,3,5,1.
  - pc_increment high 1 cycle in FETCH; gp_read/latch_ula in cycle 3; gp_write/grab_ula in cycle 4; ula_operation=2.
- rom_ready held 0 for 5 cycles in FETCH -> rom_read high 5+1 cycles; pc_increment 0 until rom_ready=1; opcode sampled only on that cycle.
- MC_OP_MASK=16'h0008, opcode=3, ula_done after 4 wait cycles -> S_ULA_WAIT for 4 cycles, then STORE_RES; timeout_err=0.
- Same op with ula_done never asserted, WAIT_MAX=15 -> 15 cycles in S_ULA_WAIT, then S_HALT; halted=1 and timeout_err=1 persist; run toggles ignored.
- opcode=4'hE -> pc_load one cycle in DECODE, no gp/ULA strobes, back to FETCH. opcode=4'hF -> S_HALT, halted=1.
- run dropped during S_ULA_OP -> STORE_RES completes, then S_IDLE. rst_n low during S_ULA_WAIT -> immediate S_IDLE, all outputs 0, timeout_err cleared.
